ps2_kbd_intr: RTL and testbench
===============================

PS2_KBD_INTR -- requirements
Module: ps2_kbd_intr

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, scan-code buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, idle clocks before a partial frame is abandoned.
REQ-003 SHALL have port clock, input, 1, single system clock; all flops on rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1, raw PS/2 clock from keyboard (asynchronous).
REQ-006 SHALL have port ps2_data, input, 1, raw PS/2 data from keyboard (asynchronous).
REQ-007 SHALL have port io_rdn, input, 1, CPU i/o read strobe, active low, one clock per lw.
REQ-008 SHALL have port m_addr, input, 32, CPU address; only bit 2 decoded (0 = data reg, 1 = status reg).
REQ-009 SHALL have port io_data, output, 32, read data to CPU, combinational from registered state.
REQ-010 SHALL have port intr1, output, 1, keyboard interrupt request to CPU, level, registered.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers plus one history flop; a PS/2 falling edge is sync_clk_prev=1 and sync_clk=0.
REQ-012 SHALL run receiver FSM IDLE -> SHIFT -> CHECK -> IDLE with 4-bit bit counter 0..10, sampling sync data on each falling edge.
REQ-013 SHALL in IDLE leave on a falling edge only if sampled data=0 (start bit); data=1 stays IDLE.
REQ-014 SHALL in SHIFT capture 8 data bits LSB first, then odd-parity bit, then stop bit; after the stop bit go to CHECK.
REQ-015 SHALL in CHECK (one clock) push the byte iff parity odd over 9 bits and stop=1; otherwise discard silently; always return to IDLE.
REQ-016 SHALL count clocks since last falling edge while in SHIFT; reaching TIMEOUT_CYCLES returns FSM to IDLE, counter cleared, no push.
REQ-017 SHALL hold received bytes in a FIFO of FIFO_DEPTH entries with count width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
REQ-018 SHALL pop on the rising edge where io_rdn=0 and m_addr[2]=0 and FIFO non-empty; pop when empty is ignored.
REQ-019 SHALL, on push with FIFO full and no pop same cycle, drop the byte and set sticky overflow flag.
REQ-020 SHALL, on simultaneous push and pop, perform both (count unchanged), including when full; no overflow set.
REQ-021 SHALL drive io_data for m_addr[2]=0 as {23'b0, ready, head_byte}, ready=FIFO non-empty; head_byte=0 when empty.
REQ-022 SHALL drive io_data for m_addr[2]=1 as {29'b0, overflow, full, ready}; a status read (io_rdn=0) clears overflow on that edge unless a new overflow occurs same cycle (set wins).
REQ-023 SHALL drive io_data regardless of io_rdn (CPU muxes by io_rdn).
REQ-024 SHALL assert intr1 registered: intr1 = FIFO non-empty after the current edge; deasserts the edge the last byte is popped.
REQ-025 SHALL have byte-complete-to-intr1 latency of 2 clocks after the stop-bit falling edge is detected (CHECK push, then flag).

Reset
REQ-026 SHALL on resetn=0 asynchronously clear FSM to IDLE, bit counter, timeout counter, FIFO pointers/count, overflow, intr1 and synchronizers (synchronizers reset to 1, bus idle).
REQ-027 SHALL discard any partial frame on reset mid-frame; reception resumes only at the next start bit after release.

Structure
REQ-028 SHALL place frame length (11), register offsets (data=0, status=4) and status bit positions in shared package kbd_pkg.
REQ-029 SHALL implement the buffer as one sub-module kbd_fifo (push/pop/full/empty/count/head) instantiated once.

Verification
REQ-030 SHALL cover: send frame 0x1C with correct odd parity -> intr1=1 two clocks after stop edge; data read returns 0x0000_011C; intr1=0 next edge.
REQ-031 SHALL cover: frame 0x1C with wrong parity, then frame with stop=0 -> no push, intr1 stays 0, status reads 0x0.
REQ-032 SHALL cover: 9 valid frames 0x01..0x09 without reads (depth 8) -> status 0x7 (overflow, full, ready); eight data reads return 0x01..0x08; status then 0x0.
REQ-033 SHALL cover: 4 bits of a frame then silence TIMEOUT_CYCLES clocks, then valid frame 0x5A -> only 0x5A received.
REQ-034 SHALL cover: FIFO full, data read on the same clock as CHECK push of 0xF0 -> count stays 8, no overflow, 0xF0 read last.
REQ-035 SHALL cover: resetn pulsed low after 5 bits of a frame -> all outputs 0, remaining bits ignored, next valid frame 0x29 received correctly.

Source files
------------

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared constants for the PS/2 keyboard interface
package kbd_pkg;

  localparam int FRAME_BITS = 11;

  localparam logic [31:0] REG_DATA_OFS   = 32'h0;
  localparam logic [31:0] REG_STATUS_OFS = 32'h4;
  localparam int          REG_SEL_BIT    = 2;

  localparam int STAT_READY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int DATA_READY_BIT = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // f = {stop, parity, data[7:0]}; good frame has odd parity over 9 bits and stop=1
  function automatic logic frame_ok(input logic [9:0] f);
    return (^f[8:0]) & f[9];
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - scan-code buffer; push/pop are pre-qualified by the caller
module kbd_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ps2_kbd_intr.sv
// rtl/ps2_kbd_intr.sv - PS/2 keyboard receiver with scan-code FIFO, CPU registers and interrupt
import kbd_pkg::*;

module ps2_kbd_intr #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        io_rdn,
  input  logic [31:0] m_addr,
  output logic [31:0] io_data,
  output logic        intr1
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic          clk_meta, sync_clk, sync_clk_prev;
  logic          data_meta, sync_data;
  logic          fall;
  logic [1:0]    state;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [9:0]    frame;
  logic          push, pop_ok, wr_ok, ovf_set, ovf_clr, overflow;
  logic          sel_status, full, empty;
  logic [7:0]    head;
  logic [CW-1:0] count, count_next;
  logic          unused_addr;

  // Synchronizers idle high so reset never fabricates a falling edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_meta      <= 1'b1;
      sync_clk      <= 1'b1;
      sync_clk_prev <= 1'b1;
      data_meta     <= 1'b1;
      sync_data     <= 1'b1;
    end else begin
      clk_meta      <= ps2_clk;
      sync_clk      <= clk_meta;
      sync_clk_prev <= sync_clk;
      data_meta     <= ps2_data;
      sync_data     <= data_meta;
    end
  end

  assign fall = sync_clk_prev & ~sync_clk;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      tmo_cnt <= '0;
      frame   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (fall && !sync_data) begin
            state   <= ST_SHIFT;
            bit_cnt <= 4'd1;
          end
        end
        ST_SHIFT: begin
          if (fall) begin
            tmo_cnt <= '0;
            frame   <= {sync_data, frame[9:1]};
            if (bit_cnt == LAST_BIT) state <= ST_CHECK;
            else                     bit_cnt <= bit_cnt + 4'd1;
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_CHECK: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign sel_status = m_addr[REG_SEL_BIT];
  assign push       = (state == ST_CHECK) && frame_ok(frame);
  assign pop_ok     = !io_rdn && !sel_status && !empty;
  // A pop on the same edge frees the slot, so a full buffer still accepts the byte
  assign wr_ok      = push && (!full || pop_ok);
  assign ovf_set    = push && full && !pop_ok;
  assign ovf_clr    = !io_rdn && sel_status;

  kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (wr_ok),
    .pop    (pop_ok),
    .wdata  (frame[7:0]),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_comb begin
    count_next = count;
    if (wr_ok && !pop_ok)      count_next = count + CW'(1);
    else if (pop_ok && !wr_ok) count_next = count - CW'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
      intr1    <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      intr1 <= (count_next != '0);
    end
  end

  always_comb begin
    io_data = '0;
    if (sel_status) begin
      io_data[STAT_READY_BIT] = !empty;
      io_data[STAT_FULL_BIT]  = full;
      io_data[STAT_OVF_BIT]   = overflow;
    end else begin
      io_data[DATA_READY_BIT] = !empty;
      io_data[7:0]            = empty ? 8'h00 : head;
    end
  end

  assign unused_addr = ^{m_addr[31:REG_SEL_BIT+1], m_addr[REG_SEL_BIT-1:0]};

endmodule

// File: tb/tb_ps2_kbd_intr.sv
// tb/tb_ps2_kbd_intr.sv - randomized self-checking bench with a queue-based reference model
import kbd_pkg::*;

module tb_ps2_kbd_intr;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 6;

  logic        clock = 1'b0;
  logic        resetn, ps2_clk, ps2_data, io_rdn;
  logic [31:0] m_addr, io_data;
  logic        intr1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  q [$];
  bit          m_ovf = 1'b0;
  logic [31:0] last_rd;

  ps2_kbd_intr #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .io_rdn   (io_rdn),
    .m_addr   (m_addr),
    .io_data  (io_data),
    .intr1    (intr1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic void model_frame(input logic [7:0] d, input bit ok);
    if (ok) begin
      if (q.size() < DEPTH) q.push_back(d);
      else                  m_ovf = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    if (addr == REG_STATUS_OFS)
      return {29'b0, m_ovf, q.size() == DEPTH, q.size() != 0};
    return (q.size() != 0) ? {23'b0, 1'b1, q[0]} : 32'h0;
  endfunction

  task automatic cpu_read(input logic [31:0] addr, input string tag);
    logic [31:0] exp;
    exp = model_rd(addr);
    @(posedge clock); #1;
    m_addr = addr;
    io_rdn = 1'b0;
    @(negedge clock);
    last_rd = io_data;
    check(tag, io_data, exp);
    @(posedge clock); #1;
    io_rdn = 1'b1;
    if (addr == REG_STATUS_OFS) m_ovf = 1'b0;
    else if (q.size() != 0)     void'(q.pop_front());
    @(negedge clock);
    check({tag, "_intr"}, {31'b0, intr1}, {31'b0, q.size() != 0});
  endtask

  // mode 1: check interrupt latency on the stop bit; mode 2: data read during the push clock
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int first, input int last, input int mode);
    logic [10:0] bits;
    bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = first; i < last; i++) begin
      @(posedge clock); #1;
      ps2_data = bits[i];
      repeat (HALF) @(posedge clock);
      #1 ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("lat_edge3", {31'b0, intr1}, 32'h0);
        @(posedge clock);
        @(negedge clock);
        check("lat_edge4", {31'b0, intr1}, 32'h1);
      end else if (i == 10 && mode == 2) begin
        repeat (3) @(posedge clock);
        #1;
        m_addr = REG_DATA_OFS;
        io_rdn = 1'b0;
        @(negedge clock);
        check("rd_at_push", io_data, model_rd(REG_DATA_OFS));
        @(posedge clock); #1;
        io_rdn = 1'b1;
        void'(q.pop_front());
      end
      repeat (HALF) @(posedge clock);
      #1 ps2_clk = 1'b1;
    end
    if (first == 0 && last == 11) begin
      repeat (8) @(posedge clock);
      model_frame(d, !bad_par && !bad_stop);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    resetn   = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    io_rdn   = 1'b1;
    m_addr   = REG_DATA_OFS;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_data", io_data, 32'h0);
    check("rst_intr", {31'b0, intr1}, 32'h0);
    #1 resetn = 1'b1;
    cpu_read(REG_STATUS_OFS, "rst_status");
    cpu_read(REG_DATA_OFS, "rst_empty_rd");

    send_frame(8'h1C, 0, 0, 0, 11, 1);
    cpu_read(REG_DATA_OFS, "rd_1c");
    check("rd_1c_const", last_rd, 32'h0000_011C);

    send_frame(8'h1C, 1, 0, 0, 11, 0);
    check("badpar_intr", {31'b0, intr1}, 32'h0);
    send_frame(8'h1C, 0, 1, 0, 11, 0);
    check("badstop_intr", {31'b0, intr1}, 32'h0);
    cpu_read(REG_STATUS_OFS, "bad_status");

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0, 11, 0);
    cpu_read(REG_STATUS_OFS, "ovf_status");
    check("ovf_status_const", last_rd, 32'h7);
    for (int i = 1; i <= 8; i++) cpu_read(REG_DATA_OFS, "ovf_drain");
    cpu_read(REG_STATUS_OFS, "ovf_after");

    send_frame(8'h6B, 0, 0, 0, 4, 0);
    repeat (TMO + 20) @(posedge clock);
    send_frame(8'h5A, 0, 0, 0, 11, 0);
    cpu_read(REG_DATA_OFS, "tmo_5a");
    check("tmo_5a_const", last_rd, 32'h0000_015A);
    cpu_read(REG_DATA_OFS, "tmo_empty");

    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 0, 0, 0, 11, 0);
    cpu_read(REG_STATUS_OFS, "full_status");
    send_frame(8'hF0, 0, 0, 0, 11, 2);
    cpu_read(REG_STATUS_OFS, "simul_status");
    check("simul_status_const", last_rd, 32'h3);
    for (int i = 0; i < 8; i++) cpu_read(REG_DATA_OFS, "simul_drain");
    check("simul_last_f0", last_rd, 32'h0000_01F0);

    send_frame(8'h33, 0, 0, 0, 11, 0);
    send_frame(8'hF0, 0, 0, 0, 5, 0);
    @(posedge clock); #1;
    resetn = 1'b0;
    m_addr = REG_DATA_OFS;
    @(negedge clock);
    check("midrst_data", io_data, 32'h0);
    check("midrst_intr", {31'b0, intr1}, 32'h0);
    m_addr = REG_STATUS_OFS;
    #1 check("midrst_status", io_data, 32'h0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    send_frame(8'hF0, 0, 0, 5, 11, 0);
    repeat (20) @(posedge clock);
    cpu_read(REG_STATUS_OFS, "midrst_after");
    send_frame(8'h29, 0, 0, 0, 11, 0);
    cpu_read(REG_DATA_OFS, "rd_29");
    check("rd_29_const", last_rd, 32'h0000_0129);

    for (int it = 0; it < 30; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        send_frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 0, 11, 0);
        @(negedge clock);
        check("rand_intr", {31'b0, intr1}, {31'b0, q.size() != 0});
      end else if (sel <= 8) begin
        cpu_read(REG_DATA_OFS, "rand_data");
      end else begin
        cpu_read(REG_STATUS_OFS, "rand_status");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
